// File: rtl/alarm_ring_ctrl.sv
// Alarm ringer sequencer: edge-triggered ring, bounded snooze count, timed auto-silence.
// Optional ALARM_ESCALATE_EN: beep pattern gated by sec_tick for the first 10 s of each ring.
module alarm_ring_ctrl #(
  parameter int SNOOZE_MINS = 9,
  parameter int MAX_SNOOZE  = 3,
  parameter int RING_SECS   = 60,
  parameter int TONE_DIV    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic [3:0] time_hours,
  input  logic [5:0] time_mins,
  input  logic       time_AM_PM,
  input  logic [3:0] alarm_hours,
  input  logic [5:0] alarm_mins,
  input  logic       alarm_AM_PM,
  output logic       SPEAKER_OUT,
  output logic       ringing,
  output logic       snoozed,
  output logic [3:0] snooze_cnt
);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED, SILENCED} state_t;

  localparam int DIV_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TONE_DIV - 1);
  localparam logic [6:0] SNOOZE_W = 7'(SNOOZE_MINS);
  localparam logic [3:0] MAX_W = 4'(MAX_SNOOZE);
  localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);

  state_t           state_q, state_d;
  logic             match, tmatch, match_q;
  logic [7:0]       ring_tmr_q, ring_tmr_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tone_q, tone_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       tgt_hours_q, tgt_hours_d;
  logic [5:0]       tgt_mins_q, tgt_mins_d;
  logic             tgt_pm_q, tgt_pm_d;
  logic [6:0]       min_sum;
  logic [5:0]       snz_mins;
  logic [3:0]       snz_hours;
  logic             snz_pm;
  logic             timeout, ring_hold;

  assign match  = (time_hours == alarm_hours) && (time_mins == alarm_mins) &&
                  (time_AM_PM == alarm_AM_PM);
  assign tmatch = (time_hours == tgt_hours_q) && (time_mins == tgt_mins_q) &&
                  (time_AM_PM == tgt_pm_q);

  // Snooze target on the 12-hour dial: 11->12 flips meridiem, 12->1 does not.
  always_comb begin
    min_sum   = {1'b0, time_mins} + SNOOZE_W;
    snz_mins  = min_sum[5:0];
    snz_hours = time_hours;
    snz_pm    = time_AM_PM;
    if (min_sum >= 7'd60) begin
      snz_mins = 6'(min_sum - 7'd60);
      if (time_hours == 4'd11) begin
        snz_hours = 4'd12;
        snz_pm    = ~time_AM_PM;
      end else if (time_hours == 4'd12) begin
        snz_hours = 4'd1;
      end else begin
        snz_hours = time_hours + 4'd1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ring_tmr_d  = ring_tmr_q;
    cnt_d       = cnt_q;
    tgt_hours_d = tgt_hours_q;
    tgt_mins_d  = tgt_mins_q;
    tgt_pm_d    = tgt_pm_q;
    timeout     = sec_tick && (ring_tmr_q == RING_LAST);
    if (!alarm_en) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (match && !match_q) begin
            state_d    = RINGING;
            ring_tmr_d = 8'd0;
          end
        end
        RINGING: begin
          if (timeout) begin
            state_d = SILENCED;
          end else if (snooze && (cnt_q < MAX_W)) begin
            state_d     = SNOOZED;
            cnt_d       = cnt_q + 4'd1;
            tgt_hours_d = snz_hours;
            tgt_mins_d  = snz_mins;
            tgt_pm_d    = snz_pm;
          end else if (sec_tick) begin
            ring_tmr_d = ring_tmr_q + 8'd1;
          end
        end
        SNOOZED: begin
          if (tmatch) begin
            state_d    = RINGING;
            ring_tmr_d = 8'd0;
          end
        end
        SILENCED: begin
          if (!match && !tmatch) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Divider and tone restart from zero on every entry into RINGING.
  always_comb begin
    ring_hold = (state_q == RINGING) && (state_d == RINGING);
    div_d     = '0;
    tone_d    = 1'b0;
    if (ring_hold) begin
      if (div_q == DIV_LAST) begin
        tone_d = ~tone_q;
      end else begin
        div_d  = div_q + DIV_W'(1);
        tone_d = tone_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ring_tmr_q  <= 8'd0;
      div_q       <= '0;
      tone_q      <= 1'b0;
      cnt_q       <= 4'd0;
      tgt_hours_q <= 4'd0;
      tgt_mins_q  <= 6'd0;
      tgt_pm_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ring_tmr_q  <= ring_tmr_d;
      div_q       <= div_d;
      tone_q      <= tone_d;
      cnt_q       <= cnt_d;
      tgt_hours_q <= tgt_hours_d;
      tgt_mins_q  <= tgt_mins_d;
      tgt_pm_q    <= tgt_pm_d;
    end
  end

  // Edge history keeps tracking through reset so a reset inside the alarm minute cannot re-ring.
  always_ff @(posedge clk) begin
    match_q <= match;
  end

`ifdef ALARM_ESCALATE_EN
  logic gate_q, gate_d;

  always_comb begin
    gate_d = 1'b1;
    if (ring_hold) begin
      gate_d = sec_tick ? ~gate_q : gate_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gate_q <= 1'b1;
    end else begin
      gate_q <= gate_d;
    end
  end

  assign SPEAKER_OUT = tone_q && (gate_q || (ring_tmr_q >= 8'd10));
`else
  assign SPEAKER_OUT = tone_q;
`endif

  assign ringing    = (state_q == RINGING);
  assign snoozed    = (state_q == SNOOZED);
  assign snooze_cnt = cnt_q;

endmodule

// File: doc/alarm_ring_ctrl.md
Name: alarm_ring_ctrl

Overview:
- Sequences the alarm speaker for the 12-hour alarm clock.
- Detects the time/alarm match and rings for a bounded period.
- Supports snooze: re-arms a target time SNOOZE_MINS ahead, up to MAX_SNOOZE times.
- Silences on enable-off or timeout. Sits between the time/alarm counters and the speaker pin, replacing a plain ringer state machine.

Parameters:
- SNOOZE_MINS, 9, minutes added to current time on snooze (1-59).
- MAX_SNOOZE, 3, maximum snoozes per alarm event (1-15).
- RING_SECS, 60, seconds of ringing before auto-silence (1-255).
- TONE_DIV, 4, clk cycles per speaker half-period (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous reset, active-high.
- sec_tick  in  1  one-clk pulse per second from the time base.
- alarm_en  in  1  alarm toggle switch level; 1 = armed.
- snooze  in  1  one-clk snooze request pulse, already debounced.
- time_hours  in  4  current hour, 1-12.
- time_mins  in  6  current minute, 0-59.
- time_AM_PM  in  1  current meridiem; 1 = PM.
- alarm_hours  in  4  alarm hour, 1-12.
- alarm_mins  in  6  alarm minute, 0-59.
- alarm_AM_PM  in  1  alarm meridiem.
- SPEAKER_OUT  out  1  square-wave tone; 0 when silent.
- ringing  out  1  1 in RINGING state.
- snoozed  out  1  1 in SNOOZED state.
- snooze_cnt  out  4  snoozes used in current event.

Behaviour:
- Reset: state IDLE; SPEAKER_OUT, ringing, snoozed, snooze_cnt = 0; ring timer, tone divider and target registers cleared.
- Reset mid-operation behaves the same.
- Signals:
  - match = {time_hours, time_mins, time_AM_PM} equals alarm.
  - tmatch = current time equals the latched snooze target.
  - match_q registers match, one cycle.
- States:
  - IDLE:
    - alarm_en && match && !match_q (rising edge) -> RINGING; ring timer loads 0.
    - Already matching when alarm_en rises -> no ring; wait for the next rising edge.
  - RINGING:
    - Ring timer increments on sec_tick.
    - Timer reaches RING_SECS -> SILENCED.
    - snooze && snooze_cnt < MAX_SNOOZE -> SNOOZED; target latches current time + SNOOZE_MINS; snooze_cnt increments.
    - snooze with snooze_cnt == MAX_SNOOZE -> ignored; keeps ringing.
  - SNOOZED:
    - tmatch -> RINGING; ring timer reloads 0.
    - snooze pulses ignored.
  - SILENCED:
    - Stays until !match && !tmatch -> IDLE; snooze_cnt clears.
    - Prevents re-trigger within the same minute.
- alarm_en low in any state -> IDLE next cycle; snooze_cnt clears.
  - Priority: alarm_en low > timeout > snooze.
  - Timeout and snooze in the same cycle -> SILENCED.
- Target arithmetic:
  - min = time_mins + SNOOZE_MINS; if >= 60, subtract 60 and carry one hour.
  - Hour carry: 11 -> 12 toggles AM_PM; 12 -> 1 keeps AM_PM; other hours increment.
  - Target is computed and registered in the snooze cycle; no multicycle path.
- Tone:
  - Divider counts clk while ringing; SPEAKER_OUT toggles every TONE_DIV cycles.
  - Outside RINGING, divider held at 0 and SPEAKER_OUT = 0.
  - First toggle occurs TONE_DIV cycles after entering RINGING.
- ringing and snoozed are registered state decodes; 1-cycle latency from the triggering input.

Optional Feature:
- Macro: ALARM_ESCALATE_EN.
- Defined: ringing starts with a beep pattern.
  - Tone gated on for 1 s, off for 1 s, toggled by sec_tick; gate starts on.
  - After 10 s of ringing, the tone becomes continuous.
  - Gate resets on each entry to RINGING.
- Undefined: continuous tone for the entire ring period; the gate logic is absent.

Test Plan:
- Arm, alarm = 7:30 AM, time steps 7:29 AM -> 7:30 AM -> ringing=1 next cycle; SPEAKER_OUT toggles every 4 clks.
- Ringing at 11:55 PM, snooze pulse -> snoozed=1, snooze_cnt=1; target 12:04 AM; time reaches 12:04 AM -> ringing=1.
- Snooze three times, then a fourth snooze while ringing -> still ringing, snooze_cnt=3; 60 sec_ticks -> SILENCED, SPEAKER_OUT=0; time 7:31 -> IDLE, snooze_cnt=0.
- alarm_en dropped in the same cycle as a snooze pulse while ringing -> IDLE, snoozed=0, snooze_cnt=0.
- reset asserted mid-ring for 1 cycle at 12:59 with a snooze target pending -> all outputs 0; no ring while time stays at the alarm minute.
- ALARM_ESCALATE_EN defined: ring 12 s -> tone present in seconds 0, 2, 4, 6, 8; absent in 1, 3, 5, 7, 9; continuous from second 10.
